// File: rtl/sp1_ram_arb_pkg.sv
// Shared definitions for the sp1_ram arbiter: default RAM geometry and the
// lock-ownership state encodings.
package sp1_ram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_LOCK_A = 2'd1,
    OWN_LOCK_B = 2'd2
  } own_e;

endpackage

// File: rtl/sp1_rr_pick.sv
// Two-way round-robin picker. hold[x] restricts the grant to requester x
// alone; otherwise prio breaks ties (0 = requester 0, 1 = requester 1).
module sp1_rr_pick (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic [1:0] hold,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (hold[0]) begin
      gnt[0] = req[0];
    end else if (hold[1]) begin
      gnt[1] = req[1];
    end else if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/sp1_ram_arb.sv
// Round-robin arbiter sharing one sp1_ram port between requesters A and B.
// Define SP1_RAM_ARB_LOCK_EN to honour a_lock/b_lock for read-modify-write.
module sp1_ram_arb
  import sp1_ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_din,
  input  logic          a_lock,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_din,
  input  logic          b_lock,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic       prio;
  own_e       own;
  own_e       own_next;
  logic [1:0] rd_pend;
  logic [1:0] gnt;
  logic [1:0] hold;

  assign hold = {own == OWN_LOCK_B, own == OWN_LOCK_A};

  sp1_rr_pick u_pick (
    .req  ({b_req, a_req}),
    .prio (prio),
    .hold (hold),
    .gnt  (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Idle requester buses are never forwarded, so X on them cannot reach the RAM.
  always_comb begin
    ram_cs  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    if (gnt[0]) begin
      ram_cs  = 1'b1;
      ram_we  = a_we;
      ram_adr = a_adr;
      ram_din = a_din;
    end else if (gnt[1]) begin
      ram_cs  = 1'b1;
      ram_we  = b_we;
      ram_adr = b_adr;
      ram_din = b_din;
    end
  end

  assign a_rvalid = rd_pend[0];
  assign b_rvalid = rd_pend[1];
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

`ifdef SP1_RAM_ARB_LOCK_EN
  // A lock is taken by a granted locked access and released either by a
  // final unlocked access or by the owner dropping its request.
  always_comb begin
    own_next = own;
    case (own)
      OWN_IDLE: begin
        if (gnt[0] && a_lock)      own_next = OWN_LOCK_A;
        else if (gnt[1] && b_lock) own_next = OWN_LOCK_B;
      end
      OWN_LOCK_A: begin
        if (!a_req || (gnt[0] && !a_lock)) own_next = OWN_IDLE;
      end
      OWN_LOCK_B: begin
        if (!b_req || (gnt[1] && !b_lock)) own_next = OWN_IDLE;
      end
      default: own_next = OWN_IDLE;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = a_lock ^ b_lock;
  assign own_next    = OWN_IDLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own <= OWN_IDLE;
    end else begin
      own <= own_next;
    end
  end

  // Priority flips to the loser only on unlocked grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio    <= 1'b0;
      rd_pend <= 2'b00;
    end else begin
      if ((own == OWN_IDLE) && (gnt != 2'b00)) begin
        prio <= gnt[0];
      end
      rd_pend <= {gnt[1] & ~b_we, gnt[0] & ~a_we};
    end
  end

endmodule

// File: tb/tb_sp1_ram_arb.sv
// Directed bench for sp1_ram_arb with a behavioural RAM and a read-data
// scoreboard. Lock-dependent expectations follow SP1_RAM_ARB_LOCK_EN.
module tb_sp1_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [9:0]  a_adr, b_adr;
  logic [31:0] a_din, b_din;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_cs, ram_we;
  logic [9:0]  ram_adr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] ram_mem [0:1023];
  logic [31:0] model_mem [0:1023];

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } rd_t;

  rd_t sb[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_adr] <= ram_din;
      else        ram_dout <= ram_mem[ram_adr];
    end
  end

  sp1_ram_arb #(.AW(10), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_adr    (a_adr),
    .a_din    (a_din),
    .a_lock   (a_lock),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_adr    (b_adr),
    .b_din    (b_din),
    .b_lock   (b_lock),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .a_rdata  (a_rdata),
    .b_rdata  (b_rdata),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_adr  (ram_adr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every output at its reset value.
  task automatic checkOutput(input string tag);
    chk({tag, ".a_gnt"},    {31'd0, a_gnt},    32'd0);
    chk({tag, ".b_gnt"},    {31'd0, b_gnt},    32'd0);
    chk({tag, ".a_rvalid"}, {31'd0, a_rvalid}, 32'd0);
    chk({tag, ".b_rvalid"}, {31'd0, b_rvalid}, 32'd0);
    chk({tag, ".ram_cs"},   {31'd0, ram_cs},   32'd0);
    chk({tag, ".ram_we"},   {31'd0, ram_we},   32'd0);
    chk({tag, ".ram_adr"},  {22'd0, ram_adr},  32'd0);
    chk({tag, ".ram_din"},  ram_din,           32'd0);
  endtask

  // Drive one cycle from a negedge, check against the expected grant eg,
  // update the model and scoreboard, then advance to the next negedge.
  task automatic applyStimulus(
    input logic ar, input logic aw, input logic [9:0] aa, input logic [31:0] ad, input logic al,
    input logic br, input logic bw, input logic [9:0] ba, input logic [31:0] bd, input logic bl,
    input logic [1:0] eg, input string tag);
    logic        e_cs, e_we, e_av, e_bv;
    logic [9:0]  e_adr;
    logic [31:0] e_din, e_d;
    rd_t         e;
    a_req = ar; a_we = aw; a_adr = aa; a_din = ad; a_lock = al;
    b_req = br; b_we = bw; b_adr = ba; b_din = bd; b_lock = bl;
    #1;
    e_cs = 1'b0; e_we = 1'b0; e_adr = '0; e_din = '0;
    if (eg[0]) begin
      e_cs = 1'b1; e_we = aw; e_adr = aa; e_din = ad;
    end else if (eg[1]) begin
      e_cs = 1'b1; e_we = bw; e_adr = ba; e_din = bd;
    end
    chk({tag, ".a_gnt"},   {31'd0, a_gnt},   {31'd0, eg[0]});
    chk({tag, ".b_gnt"},   {31'd0, b_gnt},   {31'd0, eg[1]});
    chk({tag, ".ram_cs"},  {31'd0, ram_cs},  {31'd0, e_cs});
    chk({tag, ".ram_we"},  {31'd0, ram_we},  {31'd0, e_we});
    chk({tag, ".ram_adr"}, {22'd0, ram_adr}, {22'd0, e_adr});
    if (e_cs && e_we) chk({tag, ".ram_din"}, ram_din, e_din);
    e_av = 1'b0; e_bv = 1'b0; e_d = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.port) e_bv = 1'b1;
      else        e_av = 1'b1;
      e_d = e.data;
    end
    chk({tag, ".a_rvalid"}, {31'd0, a_rvalid}, {31'd0, e_av});
    chk({tag, ".b_rvalid"}, {31'd0, b_rvalid}, {31'd0, e_bv});
    if (e_av) chk({tag, ".a_rdata"}, a_rdata, e_d);
    if (e_bv) chk({tag, ".b_rdata"}, b_rdata, e_d);
    if (eg[0]) begin
      if (aw) model_mem[aa] = ad;
      else    sb.push_back('{due: cyc + 1, port: 1'b0, data: model_mem[aa]});
    end else if (eg[1]) begin
      if (bw) model_mem[ba] = bd;
      else    sb.push_back('{due: cyc + 1, port: 1'b1, data: model_mem[ba]});
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 0, 10'd0, 32'd0, 0, 0, 0, 10'd0, 32'd0, 0, 2'b00, tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]   = 32'd0;
      model_mem[i] = 32'd0;
    end
    ram_dout = 32'd0;
    rst = 1'b0;
    a_req = 0; a_we = 0; a_adr = 0; a_din = 0; a_lock = 0;
    b_req = 0; b_we = 0; b_adr = 0; b_din = 0; b_lock = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b1;

    // Single A write then read.
    applyStimulus(1, 1, 10'h000, 32'hcafecafe, 0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "a_wr0");
    applyStimulus(1, 0, 10'h000, 32'd0,        0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "a_rd0");
    idle("a_rd0_data");

    // Preload, then full contention with alternating grants.
    applyStimulus(1, 1, 10'h001, 32'h11111111, 0, 0, 0, 10'h000, 32'd0,        0, 2'b01, "pre_a");
    applyStimulus(0, 0, 10'h000, 32'd0,        0, 1, 1, 10'h3ff, 32'h22222222, 0, 2'b10, "pre_b");
    applyStimulus(1, 0, 10'h001, 32'd0, 0, 1, 0, 10'h3ff, 32'd0, 0, 2'b01, "cont1");
    applyStimulus(1, 0, 10'h001, 32'd0, 0, 1, 0, 10'h3ff, 32'd0, 0, 2'b10, "cont2");
    applyStimulus(1, 0, 10'h001, 32'd0, 0, 1, 0, 10'h3ff, 32'd0, 0, 2'b01, "cont3");
    applyStimulus(1, 0, 10'h001, 32'd0, 0, 1, 0, 10'h3ff, 32'd0, 0, 2'b10, "cont4");

    // A wins once so B is preferred; B writes while A waits, then A reads it.
    applyStimulus(1, 0, 10'h000, 32'd0, 0, 0, 0, 10'h000, 32'd0,        0, 2'b01, "a_rd1");
    applyStimulus(1, 0, 10'h002, 32'd0, 0, 1, 1, 10'h002, 32'h55555555, 0, 2'b10, "b_wr2");
    applyStimulus(1, 0, 10'h002, 32'd0, 0, 0, 0, 10'h000, 32'd0,        0, 2'b01, "a_rd2");
    idle("a_rd2_data");

    // X on idle requester buses must not reach the RAM.
    applyStimulus(0, 1'bx, 10'bx, 32'bx, 1'bx, 0, 1'bx, 10'bx, 32'bx, 1'bx, 2'b00, "xsafe");
    chk("xsafe.ram_din", ram_din, 32'd0);
    applyStimulus(1, 0, 10'h000, 32'd0, 0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "xsafe_rd");
    idle("xsafe_rd_data");

    // Lock sequence: B is preferred now, so let B win once to restore A priority.
    applyStimulus(0, 0, 10'h000, 32'd0, 0, 1, 1, 10'h005, 32'h0000abcd, 0, 2'b10, "b_wr5");
    applyStimulus(1, 0, 10'h004, 32'd0, 1, 1, 0, 10'h004, 32'd0, 0, 2'b01, "lk1");
`ifdef SP1_RAM_ARB_LOCK_EN
    applyStimulus(1, 1, 10'h004, 32'haaaaaaaa, 0, 1, 0, 10'h004, 32'd0, 0, 2'b01, "lk2");
    applyStimulus(0, 0, 10'h000, 32'd0,        0, 1, 0, 10'h004, 32'd0, 0, 2'b10, "lk3");
`else
    applyStimulus(1, 1, 10'h004, 32'haaaaaaaa, 0, 1, 0, 10'h004, 32'd0, 0, 2'b10, "lk2");
    applyStimulus(1, 1, 10'h004, 32'haaaaaaaa, 0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "lk3");
`endif
    applyStimulus(1, 0, 10'h004, 32'd0, 0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "lk_rd");
    idle("lk_rd_data");

    // Reset while a read is pending: its rvalid is dropped.
    applyStimulus(1, 0, 10'h001, 32'd0, 0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "rst_rd");
    a_req = 0; b_req = 0;
    rst = 1'b0;
    #1;
    checkOutput("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    idle("post_rst_idle");
    applyStimulus(1, 0, 10'h001, 32'd0, 0, 0, 0, 10'h000, 32'd0, 0, 2'b01, "post_rst_rd");
    idle("post_rst_data");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
